// File: rtl/pps_pkg.sv
// pps_pkg: shared definitions for the PPS generator and receiver.
//   pps_state_e      - run-control FSM states
//   PPS_TRIM_W       - width of the signed per-period trim
//   pps_phase_width  - phase counter width for a given clock frequency,
//                      with headroom for a +127 cycle trimmed period
package pps_pkg;

    typedef enum logic {
        StIdle,
        StRun
    } pps_state_e;

    localparam int unsigned PPS_TRIM_W = 8;

    function automatic int unsigned pps_phase_width(input int unsigned freq);
        return $clog2(freq + 128);
    endfunction

endpackage

// File: rtl/pps_period_counter.sv
// pps_period_counter: phase counter for the PPS generator.
// Counts 0..period-1 while count_i is high and holds phase 0 otherwise.
// align_i loads a clamped phase and takes priority over the wrap.
// Optional feature macro: PPS_GENERATOR_TRIM_EN adds the trim handshake
// and a one-period variable wrap point.
//
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset
//   count_i           - run and advance the phase; low clears phase and trim
//   align_i           - load align_phase_i (clamped to ClockFreq-1)
//   align_phase_i     - phase value for align_i
//   trim_valid_i      - trim offer
//   trim_value_i      - signed trim, applied to one whole period
//   trim_ready_o      - trim accept (0 when trim is not built)
//   phase_o           - registered phase
//   phase_d_o         - next phase, for registered output decode
//   wrap_o            - a period ends this cycle (not set when align wins)
module pps_period_counter
    import pps_pkg::*;
#(
    parameter int unsigned ClockFreq = 125000000,
    localparam int unsigned PW = pps_phase_width(ClockFreq)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  count_i,
    input  logic                  align_i,
    input  logic [PW-1:0]         align_phase_i,
    input  logic                  trim_valid_i,
    input  logic [PPS_TRIM_W-1:0] trim_value_i,
    output logic                  trim_ready_o,
    output logic [PW-1:0]         phase_o,
    output logic [PW-1:0]         phase_d_o,
    output logic                  wrap_o
);

    localparam logic [PW-1:0] Freq   = PW'(ClockFreq);
    localparam logic [PW-1:0] FreqM1 = PW'(ClockFreq - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic [PW-1:0] wrap_at;
    logic [PW-1:0] align_clamped;
    logic          wrap;

`ifdef PPS_GENERATOR_TRIM_EN
    // One value register is enough: trim_ready stays low from the transfer
    // until the trimmed period ends, so no second trim can arrive meanwhile.
    logic                  trim_ready_q, trim_ready_d;
    logic                  trim_pend_q, trim_pend_d;
    logic                  trim_arm_q, trim_arm_d;
    logic [PPS_TRIM_W-1:0] trim_val_q, trim_val_d;

    assign wrap_at = trim_arm_q
        ? FreqM1 + {{(PW-PPS_TRIM_W){trim_val_q[PPS_TRIM_W-1]}}, trim_val_q}
        : FreqM1;
    assign trim_ready_o = trim_ready_q;

    always_comb begin
        trim_ready_d = trim_ready_q;
        trim_pend_d  = trim_pend_q;
        trim_arm_d   = trim_arm_q;
        trim_val_d   = trim_val_q;
        if (!count_i) begin
            trim_ready_d = 1'b1;
            trim_pend_d  = 1'b0;
            trim_arm_d   = 1'b0;
        end else begin
            if (trim_valid_i && trim_ready_q) begin
                trim_val_d   = trim_value_i;
                trim_pend_d  = 1'b1;
                trim_ready_d = 1'b0;
            end
            if (wrap) begin
                if (trim_arm_q) begin
                    trim_arm_d   = 1'b0;
                    trim_ready_d = 1'b1;
                end
                if (trim_pend_q) begin
                    trim_pend_d = 1'b0;
                    trim_arm_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trim_ready_q <= 1'b1;
            trim_pend_q  <= 1'b0;
            trim_arm_q   <= 1'b0;
            trim_val_q   <= '0;
        end else begin
            trim_ready_q <= trim_ready_d;
            trim_pend_q  <= trim_pend_d;
            trim_arm_q   <= trim_arm_d;
            trim_val_q   <= trim_val_d;
        end
    end
`else
    logic unused_trim;
    assign unused_trim  = ^{trim_valid_i, trim_value_i};
    assign wrap_at      = FreqM1;
    assign trim_ready_o = 1'b0;
`endif

    assign align_clamped = (align_phase_i >= Freq) ? FreqM1 : align_phase_i;

    always_comb begin
        phase_d = '0;
        wrap    = 1'b0;
        if (count_i) begin
            if (align_i) begin
                phase_d = align_clamped;
            // >= so an align beyond a shortened period still wraps next cycle
            end else if (phase_q >= wrap_at) begin
                wrap = 1'b1;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o   = phase_q;
    assign phase_d_o = phase_d;
    assign wrap_o    = wrap;

endmodule

// File: rtl/pps_generator.sv
// pps_generator: local 1PPS pulse generator in the clk domain.
// Optional feature macro: PPS_GENERATOR_TRIM_EN (per-period trim handshake).
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   enable        - run request (level)
//   align         - load align_phase into the phase counter (RUN only)
//   align_phase   - phase to load, clamped to C_CLOCK_FREQUENCY-1
//   trim_valid    - trim offer; trim_value is signed cycles for one period
//   trim_ready    - trim accept (tied 0 without the trim feature)
//   pps_out       - high while phase < C_PULSE_WIDTH
//   pps_tick      - one-cycle strobe at phase 0
//   pps_phase     - current phase
//   pps_seconds   - completed seconds since entering RUN
//   pps_active    - high while running
module pps_generator
    import pps_pkg::*;
#(
    parameter int unsigned C_CLOCK_FREQUENCY = 125000000,
    parameter int unsigned C_PULSE_WIDTH     = 12500000,
    localparam int unsigned PW = pps_phase_width(C_CLOCK_FREQUENCY)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  align,
    input  logic [PW-1:0]         align_phase,
    input  logic                  trim_valid,
    input  logic [PPS_TRIM_W-1:0] trim_value,
    output logic                  trim_ready,
    output logic                  pps_out,
    output logic                  pps_tick,
    output logic [PW-1:0]         pps_phase,
    output logic [31:0]           pps_seconds,
    output logic                  pps_active
);

    pps_state_e    state_q, state_d;
    logic [31:0]   seconds_q, seconds_d;
    logic          pps_out_q, pps_out_d;
    logic          pps_tick_q, pps_tick_d;
    logic          active_q, active_d;
    logic          count;
    logic          wrap;
    logic [PW-1:0] phase_next;

    // The entry cycle does not count: it only zeroes the phase.
    assign count = (state_q == StRun) && enable;

    pps_period_counter #(
        .ClockFreq (C_CLOCK_FREQUENCY)
    ) u_period_counter (
        .clk_i         (clk),
        .rst_i         (rst),
        .count_i       (count),
        .align_i       (align),
        .align_phase_i (align_phase),
        .trim_valid_i  (trim_valid),
        .trim_value_i  (trim_value),
        .trim_ready_o  (trim_ready),
        .phase_o       (pps_phase),
        .phase_d_o     (phase_next),
        .wrap_o        (wrap)
    );

    always_comb begin
        state_d   = enable ? StRun : StIdle;
        seconds_d = seconds_q;
        if ((state_q == StIdle) && enable) begin
            seconds_d = '0;
        end else if (wrap) begin
            seconds_d = seconds_q + 32'd1;
        end
        // Decode from the next phase so the registered outputs line up with pps_phase.
        active_d   = (state_d == StRun);
        pps_tick_d = active_d && (phase_next == '0);
        pps_out_d  = active_d && (phase_next < PW'(C_PULSE_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            seconds_q  <= '0;
            pps_out_q  <= 1'b0;
            pps_tick_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            seconds_q  <= seconds_d;
            pps_out_q  <= pps_out_d;
            pps_tick_q <= pps_tick_d;
            active_q   <= active_d;
        end
    end

    assign pps_out     = pps_out_q;
    assign pps_tick    = pps_tick_q;
    assign pps_seconds = seconds_q;
    assign pps_active  = active_q;

endmodule

// File: tb/tb_pps_generator.sv
// Bench for pps_generator at 100 Hz / 10-cycle pulse. A period-level model
// (current period length plus a queue of accepted trims) predicts every
// output; directed literal checks pin the model to hand-computed values.
module tb_pps_generator;
    import pps_pkg::*;

    localparam int unsigned F    = 100;
    localparam int unsigned PWID = 10;
    localparam int unsigned PW   = pps_phase_width(F);
`ifdef PPS_GENERATOR_TRIM_EN
    localparam bit TRIM = 1'b1;
`else
    localparam bit TRIM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, enable, align, trim_valid;
    logic [PW-1:0] align_phase;
    logic [7:0]    trim_value;
    logic          trim_ready, pps_out, pps_tick, pps_active;
    logic [PW-1:0] pps_phase;
    logic [31:0]   pps_seconds;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    pps_generator #(
        .C_CLOCK_FREQUENCY (F),
        .C_PULSE_WIDTH     (PWID)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .align       (align),
        .align_phase (align_phase),
        .trim_valid  (trim_valid),
        .trim_value  (trim_value),
        .trim_ready  (trim_ready),
        .pps_out     (pps_out),
        .pps_tick    (pps_tick),
        .pps_phase   (pps_phase),
        .pps_seconds (pps_seconds),
        .pps_active  (pps_active)
    );

    // ---------------- reference model ----------------
    bit          m_run = 1'b0;
    int          m_phase = 0;
    bit [31:0]   m_sec = '0;
    bit          m_cur_trimmed = 1'b0;
    int          m_cur_trim = 0;
    int          trim_q[$];
    int          m_len;
    bit          m_xfer;

    function automatic bit m_ready();
        return TRIM && (trim_q.size() == 0) && !m_cur_trimmed;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0; m_phase = 0; m_sec = '0;
            m_cur_trimmed = 1'b0; trim_q.delete();
        end else if (!enable) begin
            m_run = 1'b0; m_phase = 0;
            m_cur_trimmed = 1'b0; trim_q.delete();
        end else if (!m_run) begin
            m_run = 1'b1; m_phase = 0; m_sec = '0;
        end else begin
            m_xfer = TRIM && trim_valid && m_ready();
            m_len  = m_cur_trimmed ? int'(F) + m_cur_trim : int'(F);
            if (align) begin
                m_phase = (int'(align_phase) >= int'(F)) ? int'(F) - 1 : int'(align_phase);
            end else if (m_phase >= m_len - 1) begin
                m_phase = 0;
                m_sec   = m_sec + 1;
                if (trim_q.size() > 0) begin
                    m_cur_trimmed = 1'b1;
                    m_cur_trim    = trim_q.pop_front();
                end else begin
                    m_cur_trimmed = 1'b0;
                end
            end else begin
                m_phase = m_phase + 1;
            end
            if (m_xfer) trim_q.push_back(int'($signed(trim_value)));
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [PW+35:0] act_v, exp_v;
    always @(negedge clk) begin
        if (chk_on) begin
            act_v = {pps_active, pps_tick, pps_out, trim_ready, pps_phase, pps_seconds};
            exp_v = {m_run, m_run && (m_phase == 0), m_run && (m_phase < int'(PWID)),
                     m_ready(), PW'(m_phase), m_sec};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL model t=%0t act act/tick/out/rdy=%b%b%b%b ph=%0d sec=%0d exp %b%b%b%b ph=%0d sec=%0d",
                         $time, pps_active, pps_tick, pps_out, trim_ready, pps_phase, pps_seconds,
                         exp_v[PW+35], exp_v[PW+34], exp_v[PW+33], exp_v[PW+32], m_phase, m_sec);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycles until the next tick, bounded.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!pps_tick && n < 300);
    endtask

    int n;

    initial begin
        rst = 1'b1; enable = 1'b0; align = 1'b0; align_phase = '0;
        trim_valid = 1'b0; trim_value = '0;
        step(2);
        chk_on = 1'b1;
        check("rst_active", pps_active, 0);
        check("rst_tick", pps_tick, 0);
        check("rst_out", pps_out, 0);
        check("rst_phase", pps_phase, 0);
        check("rst_seconds", pps_seconds, 0);
        check("rst_ready", trim_ready, TRIM);

        // Basic run
        @(negedge clk); rst = 1'b0;
        @(negedge clk); enable = 1'b1;
        step(1);
        check("en_tick", pps_tick, 1);
        check("en_out", pps_out, 1);
        check("en_active", pps_active, 1);
        check("en_phase", pps_phase, 0);
        step(9);
        check("pulse_last", pps_out, 1);
        step(1);
        check("pulse_end", pps_out, 0);
        step(90);
        check("tick2", pps_tick, 1);
        check("sec1", pps_seconds, 1);
        step(100);
        check("tick3", pps_tick, 1);
        check("sec2", pps_seconds, 2);

        // Align to 95 at phase 40
        step(40);
        check("ph40", pps_phase, 40);
        @(negedge clk); align = 1'b1; align_phase = PW'(95);
        step(1);
        check("align95", pps_phase, 95);
        check("align_sec", pps_seconds, 2);
        @(negedge clk); align = 1'b0;
        wait_tick(n);
        check("align_next_tick", n, 5);
        check("sec3", pps_seconds, 3);

        // Align 0 on the wrap cycle, then clamp
        step(99);
        check("ph99", pps_phase, 99);
        @(negedge clk); align = 1'b1; align_phase = '0;
        step(1);
        check("coll_tick", pps_tick, 1);
        check("coll_sec", pps_seconds, 3);
        @(negedge clk); align_phase = PW'(150);
        step(1);
        check("clamp", pps_phase, 99);
        @(negedge clk); align = 1'b0;
        step(1);
        check("clamp_wrap_sec", pps_seconds, 4);

`ifdef PPS_GENERATOR_TRIM_EN
        step(30);
        @(negedge clk); trim_valid = 1'b1; trim_value = 8'hFD;
        step(1);
        check("trim_ready_low", trim_ready, 0);
        @(negedge clk); trim_valid = 1'b0;
        wait_tick(n);
        check("trim_ready_still_low", trim_ready, 0);
        wait_tick(n);
        check("trim_period", n, 97);
        check("trim_ready_back", trim_ready, 1);
        wait_tick(n);
        check("post_trim_period", n, 100);
`else
        @(negedge clk); trim_valid = 1'b1; trim_value = 8'hFD;
        step(1);
        check("notrim_ready", trim_ready, 0);
        @(negedge clk); trim_valid = 1'b0;
        wait_tick(n);
        wait_tick(n);
        check("notrim_period", n, 100);
`endif

        // Disable at phase 3, seconds held
        step(3);
        check("ph3", pps_phase, 3);
        n = int'(pps_seconds);
        @(negedge clk); enable = 1'b0;
        step(1);
        check("dis_out", pps_out, 0);
        check("dis_active", pps_active, 0);
        check("dis_sec_hold", pps_seconds, n);
        // Reset at phase 5
        @(negedge clk); enable = 1'b1;
        step(6);
        check("ph5", pps_phase, 5);
        @(negedge clk); rst = 1'b1;
        step(1);
        check("rst_mid_out", pps_out, 0);
        check("rst_mid_sec", pps_seconds, 0);
        check("rst_mid_active", pps_active, 0);
        @(negedge clk); rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 999) == 0);
            if (enable) enable = ($urandom_range(0, 299) != 0);
            else        enable = ($urandom_range(0, 4) == 0);
            align = ($urandom_range(0, 79) == 0);
            align_phase = ($urandom_range(0, 4) == 0) ? '0 : PW'($urandom_range(0, 160));
            trim_valid = ($urandom_range(0, 14) == 0);
            trim_value = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pps_generator.md
# pps_generator

Generates a local 1PPS timing pulse from the core clock, the transmit-side counterpart to the team's PPS receiver. A free-running phase counter divides `clk` down to one period per second and drives a fixed-width `pps_out` pulse, a one-cycle `pps_tick` strobe, the current phase and a seconds count. Software or a disciplining loop can re-align the phase and trim individual seconds. The block sits in the fabric clock domain, and `pps_out` feeds an output buffer toward external equipment.

## Interface
- `C_CLOCK_FREQUENCY`, default 125000000: `clk` frequency in Hz; the nominal second is this many cycles.
- `C_PULSE_WIDTH`, default 12500000: number of cycles `pps_out` stays high. Legal range is 1 ≤ value ≤ `C_CLOCK_FREQUENCY`−129.
- `clk`, input, 1 bit: core clock.
- `rst`, input, 1 bit: reset. Synchronous, active-high. One clock; all logic runs in the `clk` domain.
- `enable`, input, 1 bit: run request (level-sensitive).
- `align`, input, 1 bit: one-cycle request to load the phase counter.
- `align_phase`, input, PW bits: phase value loaded by `align`. Values ≥ `C_CLOCK_FREQUENCY` are clamped to `C_CLOCK_FREQUENCY`−1.
- `trim_valid`, input, 1 bit: trim offer.
- `trim_value`, input, 8 bits: signed trim applied to one period, −128..127 cycles.
- `trim_ready`, output, 1 bit: trim accept.
- `pps_out`, output, 1 bit: 1PPS pulse.
- `pps_tick`, output, 1 bit: one-cycle strobe at phase 0.
- `pps_phase`, output, PW bits: current phase count.
- `pps_seconds`, output, 32 bits: completed-second counter.
- `pps_active`, output, 1 bit: high while running.
- PW = `$clog2(C_CLOCK_FREQUENCY+128)`, which is 27 for the default frequency.

## Operation
- Two states:
  - IDLE → RUN when `enable`=1.
  - RUN → IDLE when `enable`=0.
  - `rst` forces IDLE.
- On entry to RUN:
  - phase = 0, `pps_seconds` = 0.
  - The first tick occurs on the entry cycle.
- In RUN, phase increments each cycle. When phase = period−1 it wraps to 0 and `pps_seconds` increments, wrapping modulo 2^32.
- Period is `C_CLOCK_FREQUENCY` by default. With an armed trim (see Configuration), the next period only is `C_CLOCK_FREQUENCY`+trim.
- Output decode, from the same registered phase:
  - `pps_tick` = 1 iff phase = 0.
  - `pps_out` = 1 iff phase < `C_PULSE_WIDTH`.
- `align` while in RUN loads `align_phase` (after clamping):
  - A load of 0 produces a tick.
  - `pps_seconds` does not change.
  - `align` while in IDLE is ignored.
- `align` on the same cycle as a wrap: `align` wins and `pps_seconds` is not incremented.
- RUN → IDLE:
  - Next cycle all outputs go to reset values except `pps_seconds`, which holds.
  - Any pending trim is discarded.

## Timing
- Reset values: `pps_out`=0, `pps_tick`=0, `pps_phase`=0, `pps_seconds`=0, `pps_active`=0. `trim_ready`=1 when trim is compiled in, otherwise 0.
- All outputs are registered and mutually cycle-aligned.
- Enable latency:
  - `enable` rises at cycle N → `pps_active`=1, `pps_tick`=1, `pps_out`=1 and `pps_phase`=0 at cycle N+1.
- `align` at cycle N → `pps_phase`=`align_phase` at N+1.
- Trim handshake:
  - Transfer occurs when `trim_valid` and `trim_ready` are both high.
  - `trim_ready` drops the cycle after the transfer.
  - The trim arms at the next wrap and applies to that whole period.
  - `trim_ready` returns high at the wrap that ends the trimmed period.
- Disable latency: `enable` falls at cycle N → outputs at reset values at N+1.
- `rst` mid-pulse: `pps_out`=0 on the next cycle, with no partial-pulse completion.

## Configuration
- Macro `PPS_GENERATOR_TRIM_EN`.
- When defined: the trim handshake and variable period compare are implemented as described above.
- When undefined:
  - `trim_valid` and `trim_value` are ignored and `trim_ready` is tied 0.
  - Period is always `C_CLOCK_FREQUENCY`.
  - The port list is unchanged.

## Structure
- Shared package `pps_pkg` holds:
  - the state enum (IDLE, RUN);
  - `PPS_TRIM_W` = 8;
  - a function returning PW for a given frequency.
  - The receiver reuses this package.
- Sub-module `pps_period_counter` contains:
  - the phase counter, wrap compare, align load and clamp;
  - the trim latch, under the macro.
- The top level holds the FSM, the seconds counter and the output decode.

## Test plan
All scenarios use `C_CLOCK_FREQUENCY`=100 and `C_PULSE_WIDTH`=10.
1. Basic run: `rst`, then `enable`=1 at cycle 5 → `pps_tick` at cycles 6, 106 and 206; `pps_out` high during 6–15; `pps_seconds`=2 at cycle 206.
2. Align: `align` with `align_phase`=95 at phase 40 → phase 95 next cycle; next tick 5 cycles later; `pps_seconds` unchanged by the load.
3. Align collision and clamp: `align` with `align_phase`=0 on the wrap cycle → tick with no seconds increment. `align_phase`=150 → phase 99.
4. Trim (macro on): `trim_value`=−3 accepted mid-second → the following period is 97 cycles and the next is 100; `trim_ready` is low between the transfer and the end of the 97-cycle period. With the macro off: `trim_ready`=0 and all periods are 100.
5. Disable and reset: `enable`=0 at phase 3 → `pps_out`=0 and `pps_active`=0 the next cycle, `pps_seconds` held. `rst` at phase 5 → all outputs 0 on the next cycle.
